// File: rtl/trb_bus_pkg.sv
// Shared definitions for the TRB register bus: widths, completion status codes
// and the initiator FSM state encoding.
package trb_bus_pkg;

   localparam int TRB_ADDR_W = 16;
   localparam int TRB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_NACK    = 2'd1,
      ST_UNKNOWN = 2'd2,
      ST_TIMEOUT = 2'd3
   } rsp_status_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } trb_state_e;

endpackage

// File: rtl/trb_reg_initiator_if.sv
// Command, TRB bus and response signals of the register initiator.
// The master modport is the initiator's view; slave is the environment's.
interface trb_reg_initiator_if;
   import trb_bus_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [TRB_ADDR_W-1:0] cmd_addr;
   logic [TRB_DATA_W-1:0] cmd_wdata;

   logic [TRB_DATA_W-1:0] data;
   logic [TRB_ADDR_W-1:0] addr;
   logic                  wr;
   logic                  rd;
   logic [TRB_DATA_W-1:0] rdata;
   logic                  ack;
   logic                  nack;
   logic                  unknown;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_status;
   logic [TRB_DATA_W-1:0] rsp_rdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  rdata, ack, nack, unknown,
      input  rsp_ready,
      output cmd_ready,
      output data, addr, wr, rd,
      output rsp_valid, rsp_status, rsp_rdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output rdata, ack, nack, unknown,
      output rsp_ready,
      input  cmd_ready,
      input  data, addr, wr, rd,
      input  rsp_valid, rsp_status, rsp_rdata
   );

endinterface

// File: rtl/trb_timeout_counter.sv
// Counts WAIT cycles without a response; expired flags the cycle in which the
// count would reach LIMIT, so a response in that same cycle still takes priority.
module trb_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/trb_reg_initiator.sv
// TRB register bus master: turns one command into a single-strobe register
// transaction with NACK retry and timeout, and reports status plus read data.
module trb_reg_initiator
   import trb_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 2
) (
   input  logic                Cclk,
   input  logic                rst,
   trb_reg_initiator_if.master bus,
   output logic                busy,
   output logic [7:0]          stray_cnt
);

   trb_state_e            state_q, state_d;
   logic                  write_q, write_d;
   logic [TRB_ADDR_W-1:0] addr_q, addr_d;
   logic [TRB_DATA_W-1:0] data_q, data_d;
   logic                  wr_q, wr_d;
   logic                  rd_q, rd_d;
   logic [7:0]            retry_q, retry_d;
   logic                  rsp_valid_q, rsp_valid_d;
   rsp_status_e           status_q, status_d;
   logic [TRB_DATA_W-1:0] rdata_q, rdata_d;
   logic [7:0]            stray_q, stray_d;

   logic                  any_rsp;
   logic                  tmo_clear;
   logic                  tmo_en;
   logic                  tmo_expired;

   assign any_rsp = bus.ack | bus.nack | bus.unknown;

   trb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (Cclk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      retry_d     = retry_q;
      rsp_valid_d = rsp_valid_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      tmo_clear   = 1'b0;
      tmo_en      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               write_d = bus.cmd_write;
               addr_d  = bus.cmd_addr;
               data_d  = bus.cmd_wdata;
               retry_d = '0;
               wr_d    = bus.cmd_write;
               rd_d    = !bus.cmd_write;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_clear = 1'b1;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            tmo_en = !any_rsp;
            // Priority: unknown > nack > ack > timeout.
            if (bus.unknown) begin
               status_d    = ST_UNKNOWN;
               rdata_d     = '0;
               rsp_valid_d = 1'b1;
               state_d     = S_DONE;
            end else if (bus.nack) begin
               if (retry_q < 8'(MAX_RETRY)) begin
                  retry_d = retry_q + 8'd1;
                  state_d = S_GAP;
               end else begin
                  status_d    = ST_NACK;
                  rdata_d     = '0;
                  rsp_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
            end else if (bus.ack) begin
               status_d    = ST_OK;
               rdata_d     = write_q ? '0 : bus.rdata;
               rsp_valid_d = 1'b1;
               state_d     = S_DONE;
            end else if (tmo_expired) begin
               status_d    = ST_TIMEOUT;
               rdata_d     = '0;
               rsp_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_GAP: begin
            wr_d    = write_q;
            rd_d    = !write_q;
            state_d = S_ISSUE;
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      stray_d = stray_q;
      if ((state_q != S_WAIT) && any_rsp && (stray_q != 8'hFF)) begin
         stray_d = stray_q + 8'd1;
      end
   end

   always_ff @(posedge Cclk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         retry_q     <= '0;
         rsp_valid_q <= 1'b0;
         status_q    <= ST_OK;
         rdata_q     <= '0;
         stray_q     <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         retry_q     <= retry_d;
         rsp_valid_q <= rsp_valid_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         stray_q     <= stray_d;
      end
   end

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign bus.addr       = addr_q;
   assign bus.data       = data_q;
   assign bus.wr         = wr_q;
   assign bus.rd         = rd_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_status = status_q;
   assign bus.rsp_rdata  = rdata_q;
   assign stray_cnt      = stray_q;

endmodule

// File: tb/tb_trb_reg_initiator.sv
// Self-checking bench for trb_reg_initiator: directed vector table, corner
// sequences and randomized transactions against a latency/status reference model.
module tb_trb_reg_initiator;

   localparam int TMO = 16;
   localparam int MR  = 2;

   logic       Cclk;
   logic       rst;
   logic       busy;
   logic [7:0] stray_cnt;

   trb_reg_initiator_if bif ();

   trb_reg_initiator #(
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (MR)
   ) dut (
      .Cclk      (Cclk),
      .rst       (rst),
      .bus       (bif.master),
      .busy      (busy),
      .stray_cnt (stray_cnt)
   );

   initial Cclk = 1'b0;
   always #5 Cclk = ~Cclk;

   int checks = 0;
   int errors = 0;
   int exp_stray = 0;

   // Responder script: per attempt a response kind {unknown,nack,ack} and the
   // delay in cycles after the strobe; kind 0 means the responder stays silent.
   logic [2:0]  s_kind [3];
   int          s_dly  [3];
   logic [31:0] s_rdata;
   bit          pulse_issue;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [31:0] wd;
      logic [31:0] rdv;
      logic [2:0]  k0, k1, k2;
      int          d0, d1, d2;
      logic [1:0]  st;
      logic [31:0] erd;
      int          nstr;
      int          lat;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected outcome from the responder script: each attempt either finishes
   // after its response delay, times out after TMO silent cycles, or retries.
   function automatic void model(input logic w, input logic [31:0] rdv,
                                 output logic [1:0] st, output logic [31:0] erd,
                                 output int nstr, output int lat);
      lat  = 1;
      nstr = 0;
      st   = 2'd0;
      erd  = 32'h0;
      for (int i = 0; i <= MR; i++) begin
         nstr++;
         if (s_kind[i] == 3'b000 || s_dly[i] > TMO) begin
            st = 2'd3; lat += TMO + 1; return;
         end
         if (s_kind[i][2]) begin
            st = 2'd2; lat += s_dly[i] + 1; return;
         end
         if (s_kind[i][1]) begin
            if (i < MR) begin
               lat += s_dly[i] + 2;
               continue;
            end
            st = 2'd1; lat += s_dly[i] + 1; return;
         end
         st = 2'd0; erd = w ? 32'h0 : rdv; lat += s_dly[i] + 1; return;
      end
   endfunction

   task automatic run_txn(input logic w, input logic [15:0] a, input logic [31:0] wd,
                          input logic [1:0] e_st, input logic [31:0] e_rd,
                          input int e_str, input int e_lat, input int hold,
                          input string tag);
      int att = -1;
      int scyc = 0;
      int strobes = 0;
      int lat = -1;
      chk({tag, "_cmd_ready"}, {31'b0, bif.cmd_ready}, 32'd1);
      bif.cmd_valid = 1'b1;
      bif.cmd_write = w;
      bif.cmd_addr  = a;
      bif.cmd_wdata = wd;
      @(posedge Cclk); #1;
      bif.cmd_valid = 1'b0;
      bif.cmd_addr  = ~a;
      bif.cmd_wdata = ~wd;
      if (pulse_issue) exp_stray++;
      for (int cyc = 1; cyc <= 150; cyc++) begin
         bif.ack = 1'b0; bif.nack = 1'b0; bif.unknown = 1'b0;
         bif.rdata = $urandom;
         if (bif.rsp_valid) begin
            lat = cyc;
            break;
         end
         if (bif.wr || bif.rd) begin
            strobes++;
            att++;
            scyc = cyc;
            chk({tag, "_wr"},   {31'b0, bif.wr}, {31'b0, w});
            chk({tag, "_rd"},   {31'b0, bif.rd}, {31'b0, !w});
            chk({tag, "_addr"}, {16'b0, bif.addr}, {16'b0, a});
            chk({tag, "_data"}, bif.data, wd);
            if (pulse_issue) bif.ack = 1'b1;
         end
         if (att >= 0 && att <= MR && s_kind[att] != 3'b000 && (cyc - scyc) == s_dly[att]) begin
            {bif.unknown, bif.nack, bif.ack} = s_kind[att];
            bif.rdata = s_rdata;
         end
         @(posedge Cclk); #1;
      end
      bif.ack = 1'b0; bif.nack = 1'b0; bif.unknown = 1'b0;
      chk({tag, "_latency"}, lat, e_lat);
      chk({tag, "_strobes"}, strobes, e_str);
      chk({tag, "_status"}, {30'b0, bif.rsp_status}, {30'b0, e_st});
      chk({tag, "_rdata"}, bif.rsp_rdata, e_rd);
      chk({tag, "_stray"}, {24'b0, stray_cnt}, exp_stray);
      for (int h = 0; h < hold; h++) begin
         chk({tag, "_hold_valid"}, {31'b0, bif.rsp_valid}, 32'd1);
         chk({tag, "_hold_status"}, {30'b0, bif.rsp_status}, {30'b0, e_st});
         chk({tag, "_hold_ready"}, {31'b0, bif.cmd_ready}, 32'd0);
         @(posedge Cclk); #1;
      end
      bif.rsp_ready = 1'b1;
      @(posedge Cclk); #1;
      bif.rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'b0, bif.rsp_valid}, 32'd0);
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic load_vec(input int i);
      s_kind[0] = tbl[i].k0; s_kind[1] = tbl[i].k1; s_kind[2] = tbl[i].k2;
      s_dly[0]  = tbl[i].d0; s_dly[1]  = tbl[i].d1; s_dly[2]  = tbl[i].d2;
      s_rdata   = tbl[i].rdv;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr"},         {31'b0, bif.wr}, 32'd0);
      chk({tag, "_rd"},         {31'b0, bif.rd}, 32'd0);
      chk({tag, "_addr"},       {16'b0, bif.addr}, 32'd0);
      chk({tag, "_data"},       bif.data, 32'd0);
      chk({tag, "_rsp_valid"},  {31'b0, bif.rsp_valid}, 32'd0);
      chk({tag, "_rsp_status"}, {30'b0, bif.rsp_status}, 32'd0);
      chk({tag, "_rsp_rdata"},  bif.rsp_rdata, 32'd0);
      chk({tag, "_stray"},      {24'b0, stray_cnt}, 32'd0);
      chk({tag, "_cmd_ready"},  {31'b0, bif.cmd_ready}, 32'd1);
      chk({tag, "_busy"},       {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  st;
      logic [31:0] erd;
      logic [31:0] rdv;
      logic        w;
      int          nstr;
      int          lat;
      int          bad;

      tbl[0] = '{1'b0, 16'h00C1, 32'h0,        32'h00000040, 3'b001, 3'b000, 3'b000, 2,  0, 0, 2'd0, 32'h00000040, 1, 4};
      tbl[1] = '{1'b1, 16'h00C2, 32'h80000000, 32'hDEADBEEF, 3'b001, 3'b000, 3'b000, 1,  0, 0, 2'd0, 32'h0,        1, 3};
      tbl[2] = '{1'b1, 16'h0010, 32'h00000011, 32'h0,        3'b010, 3'b010, 3'b010, 1,  1, 1, 2'd1, 32'h0,        3, 9};
      tbl[3] = '{1'b0, 16'h0020, 32'h0,        32'h0,        3'b000, 3'b000, 3'b000, 0,  0, 0, 2'd3, 32'h0,        1, 18};
      tbl[4] = '{1'b0, 16'h0030, 32'h0,        32'h00000055, 3'b101, 3'b000, 3'b000, 3,  0, 0, 2'd2, 32'h0,        1, 5};
      tbl[5] = '{1'b0, 16'h0040, 32'h0,        32'h00000066, 3'b100, 3'b000, 3'b000, 16, 0, 0, 2'd2, 32'h0,        1, 18};
      tbl[6] = '{1'b0, 16'h0050, 32'h0,        32'h00001234, 3'b001, 3'b000, 3'b000, 16, 0, 0, 2'd0, 32'h00001234, 1, 18};
      tbl[7] = '{1'b0, 16'h0060, 32'h0,        32'h0000CAFE, 3'b010, 3'b001, 3'b000, 2,  3, 0, 2'd0, 32'h0000CAFE, 2, 9};
      tbl[8] = '{1'b1, 16'h0070, 32'h0000A5A5, 32'h0,        3'b011, 3'b001, 3'b000, 1,  1, 0, 2'd0, 32'h0,        2, 6};
      tbl[9] = '{1'b0, 16'h0080, 32'h0,        32'h0,        3'b010, 3'b010, 3'b100, 1,  4, 2, 2'd2, 32'h0,        3, 13};

      bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
      bif.rdata = '0; bif.ack = 1'b0; bif.nack = 1'b0; bif.unknown = 1'b0;
      bif.rsp_ready = 1'b0;
      pulse_issue = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs("reset");
      @(posedge Cclk); #1;
      rst = 1'b0;

      // Silent responder times out, then a late ack is only counted as stray.
      load_vec(3);
      run_txn(1'b0, 16'h0AAA, 32'h0, 2'd3, 32'h0, 1, 18, 0, "timeout");
      bif.ack = 1'b1;
      @(posedge Cclk); #1;
      bif.ack = 1'b0;
      exp_stray++;
      chk("late_ack_stray", {24'b0, stray_cnt}, 32'd1);

      // An ack during ISSUE is ignored; the real ack two cycles later completes.
      pulse_issue = 1'b1;
      load_vec(0);
      run_txn(1'b0, 16'h00C1, 32'h0, 2'd0, 32'h40, 1, 4, 1, "issue_pulse");
      pulse_issue = 1'b0;

      for (int i = 0; i < 10; i++) begin
         load_vec(i);
         run_txn(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].st, tbl[i].erd,
                 tbl[i].nstr, tbl[i].lat, (i == 0) ? 5 : (i % 3), $sformatf("vec%0d", i));
      end

      for (int n = 0; n < 40; n++) begin
         w   = 1'($urandom_range(0, 1));
         rdv = $urandom;
         for (int k = 0; k < 3; k++) begin
            s_kind[k] = 3'($urandom_range(0, 7));
            s_dly[k]  = $urandom_range(1, 18);
         end
         s_rdata = rdv;
         model(w, rdv, st, erd, nstr, lat);
         run_txn(w, 16'($urandom), $urandom, st, erd, nstr, lat,
                 $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      // Reset while the strobe is high abandons the transaction.
      bif.cmd_valid = 1'b1; bif.cmd_write = 1'b1;
      bif.cmd_addr = 16'h1234; bif.cmd_wdata = 32'h5555AAAA;
      @(posedge Cclk); #1;
      bif.cmd_valid = 1'b0;
      chk("rst_issue_pre_wr", {31'b0, bif.wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      exp_stray = 0;
      check_reset_outputs("rst_issue");
      @(posedge Cclk); #1;
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bif.rsp_valid || bif.wr || bif.rd) bad++;
         @(posedge Cclk); #1;
      end
      chk("rst_issue_no_response", bad, 32'd0);

      // Reset while a response is pending drops it immediately.
      bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_addr = 16'h0077;
      @(posedge Cclk); #1;
      bif.cmd_valid = 1'b0;
      @(posedge Cclk); #1;
      bif.ack = 1'b1; bif.rdata = 32'h00000077;
      @(posedge Cclk); #1;
      bif.ack = 1'b0;
      chk("rst_done_pre_valid", {31'b0, bif.rsp_valid}, 32'd1);
      chk("rst_done_pre_rdata", bif.rsp_rdata, 32'h77);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_done");
      @(posedge Cclk); #1;
      rst = 1'b0;

      // New command accepted directly after reset release.
      load_vec(1);
      run_txn(1'b1, 16'h00C2, 32'h80000000, 2'd0, 32'h0, 1, 3, 0, "post_rst");

      // Stray counter saturates at 255.
      bif.ack = 1'b1;
      for (int c = 0; c < 260; c++) @(posedge Cclk);
      #1;
      bif.ack = 1'b0;
      chk("stray_saturate", {24'b0, stray_cnt}, 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trb_reg_initiator.md
Name: trb_reg_initiator

Overview:
- Bus-master end of the 32-bit TRB register interface: data, addr, wr, rd out; rdata, ack, nack, unknown in.
- Converts single commands from a local controller (test sequencer or self-calibration FSM) into one-strobe register transactions aimed at a TDC's communication bridge.
- Handles NACK retry and timeout, and returns read data plus a completion status.

Parameters:
- TIMEOUT_CYCLES, 16: WAIT cycles without ack, nack or unknown before status TIMEOUT; legal range 2..255.
- MAX_RETRY, 2: re-issues allowed after a NACK; 0 disables retry.

Ports:
- Cclk  in  1  communication clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  16  register address.
- cmd_wdata  in  32  write data.
- data  out  32  write data to the responder.
- addr  out  16  address to the responder.
- wr  out  1  write strobe, one cycle.
- rd  out  1  read strobe, one cycle.
- rdata  in  32  read data from the responder.
- ack  in  1  transaction acknowledged.
- nack  in  1  transaction refused.
- unknown  in  1  address not decoded.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  0 OK, 1 NACK, 2 UNKNOWN, 3 TIMEOUT.
- rsp_rdata  out  32  captured read data.
- busy  out  1  high in any state other than IDLE.
- stray_cnt  out  8  count of ack/nack/unknown pulses seen outside WAIT; saturates at 255.

Behaviour:
- Reset (asynchronous, immediate):
  - Registered outputs go low immediately: wr=0, rd=0, data=0, addr=0, rsp_valid=0, rsp_status=0, rsp_rdata=0, stray_cnt=0.
  - cmd_ready and busy are decoded from state. In reset state (IDLE) cmd_ready=1 and busy=0.
  - Reset during an open transaction abandons it. No response is produced.
- FSM states: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE: cmd_ready=1. On accept, latch cmd_write, cmd_addr and cmd_wdata (addr and data outputs take the latched values), clear retry count, go to ISSUE.
- ISSUE (exactly 1 cycle): wr=cmd_write, rd=!cmd_write; clear timeout counter; go to WAIT. A response pulse during ISSUE is ignored and counted as stray.
- WAIT: each cycle with no response increments the timeout counter. Response priority when several inputs are high together: unknown > nack > ack.
  - ack: rsp_status=0; rsp_rdata=rdata on reads, 0 on writes; go to DONE.
  - unknown: rsp_status=2, rsp_rdata=0, go to DONE. No retry.
  - nack with retry count < MAX_RETRY: increment retry count, go to GAP.
  - nack with retry count = MAX_RETRY: rsp_status=1, rsp_rdata=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no response in that cycle: rsp_status=3, rsp_rdata=0, go to DONE. A response in that same cycle wins over timeout.
- GAP (1 cycle, all strobes low): go to ISSUE. addr and data are unchanged.
- DONE: rsp_valid=1; rsp_status and rsp_rdata held stable. When rsp_ready=1: rsp_valid drops the next cycle and the FSM goes to IDLE.
- addr and data are held stable from ISSUE until the next accept. wr and rd are never high in any state except ISSUE, and never high together.
- Latency: accept at cycle T, strobe at T+1, earliest ack at T+2, rsp_valid at T+3.
- Each NACK retry adds 2 + (WAIT cycles spent) to the latency.
- stray_cnt: +1 per cycle in which any response input is high while the FSM is not in WAIT; saturates at 255.
- Timeout counter width is 8 bits.

Decomposition:
- Shared package trb_bus_pkg holds:
  - status codes: ST_OK=0, ST_NACK=1, ST_UNKNOWN=2, ST_TIMEOUT=3;
  - FSM state encoding;
  - width constants: TRB_ADDR_W=16, TRB_DATA_W=32.
- One sub-module, trb_timeout_counter:
  - inputs: clear, enable;
  - output: expired;
  - parameter: LIMIT.

Test Plan:
- Read 0x00C1, responder ack 2 cycles after rd with rdata=0x00000040 -> exactly one rd pulse, addr=0x00C1; rsp_status=0, rsp_rdata=0x00000040, rsp_valid at T+4.
- Write 0x00C2 with 0x80000000, ack 1 cycle after wr -> wr high one cycle, data=0x80000000; rsp_status=0, rsp_rdata=0.
- Responder always nacks, MAX_RETRY=2 -> three wr pulses each separated by at least one low GAP cycle; rsp_status=1.
- No response, TIMEOUT_CYCLES=16 -> rsp_status=3 exactly 16 WAIT cycles after the strobe; a late ack afterwards -> stray_cnt=1.
- Same-cycle ack+unknown -> rsp_status=2. Unknown and ack arriving in the same cycle as expiry -> response wins, rsp_status=2 / 0 respectively.
- Assert rst in WAIT -> wr, rd and rsp_valid low immediately, no response produced; new command accepted right after rst falls. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_status stable, cmd_ready=0 throughout.
